// File: rtl/scalar_bank_loader.sv
// Double-buffered scalar operand loader: beats stream into a shadow bank, and a
// swap command commits the shadow bank to the active bank feeding the scalar units.
module scalar_bank_loader #(
    parameter int scalar_data_width_p = 32,
    parameter int read_bus_width_p    = 64,
    parameter int max_beats_p         = 4,
    localparam int num_lanes_p        = read_bus_width_p / scalar_data_width_p,
    localparam int num_elems_p        = num_lanes_p * max_beats_p,
    localparam int len_width_p        = $clog2(max_beats_p + 1)
) (
    input  logic                                              clk_i,
    input  logic                                              reset_i,
    input  logic                                              start_i,
    input  logic [len_width_p-1:0]                            len_i,
    input  logic [read_bus_width_p-1:0]                       read_bus_i,
    input  logic                                              load_valid_i,
    output logic                                              load_ready_o,
    input  logic                                              swap_i,
    output logic                                              busy_o,
    output logic                                              done_o,
    output logic                                              active_valid_o,
    output logic [len_width_p-1:0]                            beat_count_o,
    output logic [num_elems_p-1:0][scalar_data_width_p-1:0]   scalar_values_o
);

    generate
        if (read_bus_width_p % scalar_data_width_p != 0) begin : g_bad_width
            $error("read_bus_width_p must be a multiple of scalar_data_width_p");
        end
        if (max_beats_p < 1) begin : g_bad_beats
            $error("max_beats_p must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    localparam logic [len_width_p-1:0] max_len_c = len_width_p'(max_beats_p);
    localparam logic [len_width_p-1:0] one_c     = len_width_p'(1);

    state_t                                          state, state_n;
    logic [len_width_p-1:0]                          len_q, len_eff;
    logic [len_width_p-1:0]                          beat_count;
    logic                                            done_q, active_valid;
    logic                                            accept, last_beat;
    logic [max_beats_p-1:0][read_bus_width_p-1:0]    shadow;
    logic [num_elems_p-1:0][scalar_data_width_p-1:0] active;

    // Zero or out-of-range lengths mean a full bank.
    assign len_eff = (len_i == '0 || len_i > max_len_c) ? max_len_c : len_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n      = state;
        load_ready_o = 1'b0;
        busy_o       = 1'b0;
        accept       = 1'b0;
        last_beat    = 1'b0;
        case (state)
            IDLE: if (start_i) state_n = LOAD;
            LOAD: begin
                load_ready_o = 1'b1;
                busy_o       = 1'b1;
                accept       = load_valid_i;
                last_beat    = load_valid_i && (beat_count + one_c == len_q);
                if (last_beat) state_n = FULL;
            end
            FULL: begin
                busy_o = 1'b1;
                if (swap_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            len_q        <= max_len_c;
            beat_count   <= '0;
            done_q       <= 1'b0;
            active_valid <= 1'b0;
            shadow       <= '0;
            active       <= '0;
        end else begin
            done_q <= last_beat;
            if (state == IDLE && start_i) begin
                len_q      <= len_eff;
                beat_count <= '0;
                shadow     <= '0;
            end
            if (accept) begin
                // The shadow bank is beat-major, so a whole beat lands in one slot.
                for (int b = 0; b < max_beats_p; b++)
                    if (beat_count == len_width_p'(b)) shadow[b] <= read_bus_i;
                beat_count <= beat_count + one_c;
            end
            if (state == FULL && swap_i) begin
                active       <= shadow;
                active_valid <= 1'b1;
            end
        end
    end

    assign done_o          = done_q;
    assign active_valid_o  = active_valid;
    assign beat_count_o    = beat_count;
    assign scalar_values_o = active;

endmodule

// File: tb/tb_scalar_bank_loader.sv
// Directed bench for scalar_bank_loader at default parameters (2 lanes x 4 beats).
module tb_scalar_bank_loader;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, valid, swap;
    logic [2:0]        len_in;
    logic [63:0]       bus;
    logic              ready, busy, done, av;
    logic [2:0]        bc;
    logic [7:0][31:0]  vals;

    int n_chk = 0;
    int n_bad = 0;
    int n_done = 0;
    logic [255:0] exp_a, exp_s, exp_y, exp_c;

    always #5 clk = ~clk;

    scalar_bank_loader dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .start_i         (start),
        .len_i           (len_in),
        .read_bus_i      (bus),
        .load_valid_i    (valid),
        .load_ready_o    (ready),
        .swap_i          (swap),
        .busy_o          (busy),
        .done_o          (done),
        .active_valid_o  (av),
        .beat_count_o    (bc),
        .scalar_values_o (vals)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) n_done++;
    endtask

    task automatic start_load(input logic [2:0] len);
        start = 1'b1; len_in = len;
        tick();
        start = 1'b0; len_in = '0;
    endtask

    task automatic beat(input logic [63:0] d);
        valid = 1'b1; bus = d;
        tick();
        valid = 1'b0; bus = '0;
    endtask

    task automatic swap_bank();
        swap = 1'b1;
        tick();
        swap = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; swap = 1'b0; len_in = '0; bus = '0;
        exp_a = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        exp_s = {32'd0, 32'd0, 32'd0, 32'd0, 32'hC, 32'hD, 32'hA, 32'hB};
        exp_y = {32'h18, 32'h17, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11};
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_av", av, 0);
        chk("rst_bc", bc, 0);
        chk("rst_vals", vals, 0);

        // basic back-to-back load of 4 beats
        n_done = 0;
        start_load(3'd4);
        chk("basic_ready", ready, 1);
        chk("basic_busy", busy, 1);
        chk("basic_bc0", bc, 0);
        for (int k = 0; k < 4; k++) beat({32'(2*k+2), 32'(2*k+1)});
        chk("basic_done", done, 1);
        chk("basic_full_ready", ready, 0);
        chk("basic_bc4", bc, 4);
        chk("basic_vals_pre", vals, 0);
        tick();
        chk("basic_done_drop", done, 0);
        chk("basic_done_cnt", n_done, 1);
        swap_bank();
        chk("basic_vals", vals, exp_a);
        chk("basic_av", av, 1);
        chk("basic_busy_off", busy, 0);
        chk("basic_bc_hold", bc, 4);

        // swap in IDLE is ignored
        swap_bank();
        chk("idle_swap_busy", busy, 0);
        chk("idle_swap_vals", vals, exp_a);

        // alternate-cycle valid gaps
        n_done = 0;
        start_load(3'd4);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("gap_bc_idle%0d", k), bc, k);
            beat({32'(2*k+2), 32'(2*k+1)});
            chk($sformatf("gap_bc_acc%0d", k), bc, k + 1);
        end
        chk("gap_done_cnt", n_done, 1);
        swap_bank();
        chk("gap_vals", vals, exp_a);

        // short load, extra beat and start while FULL
        start_load(3'd2);
        beat({32'hA, 32'hB});
        beat({32'hC, 32'hD});
        chk("short_ready", ready, 0);
        valid = 1'b1; bus = {32'hEE, 32'hFF}; start = 1'b1; len_in = 3'd4;
        tick();
        valid = 1'b0; bus = '0; start = 1'b0; len_in = '0;
        chk("short_bc", bc, 2);
        chk("short_ready2", ready, 0);
        chk("short_busy", busy, 1);
        swap_bank();
        chk("short_vals", vals, exp_s);

        // double buffering with stray start/swap during LOAD
        start_load(3'd4);
        beat({32'h12, 32'h11});
        start = 1'b1; len_in = 3'd1; swap = 1'b1;
        tick();
        start = 1'b0; len_in = '0; swap = 1'b0;
        chk("dbl_bc", bc, 1);
        chk("dbl_vals_load", vals, exp_s);
        beat({32'h14, 32'h13});
        beat({32'h16, 32'h15});
        chk("dbl_ready3", ready, 1);
        beat({32'h18, 32'h17});
        chk("dbl_full", ready, 0);
        repeat (3) tick();
        chk("dbl_vals_hold", vals, exp_s);
        swap_bank();
        chk("dbl_vals_y", vals, exp_y);

        // length clamping: 0 and 7 both mean 4 beats
        for (int t = 0; t < 2; t++) begin
            start_load(t == 0 ? 3'd0 : 3'd7);
            for (int k = 0; k < 3; k++) beat({32'(100*t+2*k+2), 32'(100*t+2*k+1)});
            chk($sformatf("clamp%0d_ready3", t), ready, 1);
            beat({32'(100*t+8), 32'(100*t+7)});
            chk($sformatf("clamp%0d_ready4", t), ready, 0);
            chk($sformatf("clamp%0d_bc", t), bc, 4);
            swap_bank();
        end
        exp_c = {32'd108, 32'd107, 32'd106, 32'd105, 32'd104, 32'd103, 32'd102, 32'd101};
        chk("clamp_vals", vals, exp_c);

        // reset mid-load with committed active bank
        start_load(3'd4);
        beat({32'h22, 32'h21});
        beat({32'h24, 32'h23});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_av", av, 0);
        chk("mid_rst_bc", bc, 0);
        chk("mid_rst_vals", vals, 0);
        n_done = 0;
        start_load(3'd1);
        beat({32'h55, 32'h66});
        chk("post_rst_ready", ready, 0);
        chk("post_rst_done", n_done, 1);
        swap_bank();
        chk("post_rst_vals", vals, {192'd0, 32'h55, 32'h66});
        chk("post_rst_av", av, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
